// File: rtl/calc_param.sv
// Keypad calculator: valid/ready key commands drive an unsigned accumulator; the result is shown on DIGITS seven-segment displays.
// Busy for VAL_W+1 cycles per command (2*VAL_W+1 when a multiply is evaluated); commands offered while busy are dropped.
module calc_param #(
   parameter int DIGITS = 8,
   parameter int VAL_W  = $clog2(10**DIGITS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            cmd,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [7*DIGITS-1:0]   displays,
   output logic [1:0]            status,
   output logic [VAL_W-1:0]      digits
);

   localparam int W2    = 2*VAL_W;
   localparam int BCD_W = 4*DIGITS;
   localparam int CNT_W = $clog2(VAL_W+1);
   localparam int ND_W  = $clog2(DIGITS+1);
   localparam logic [W2-1:0]    MAX_W    = W2'(10**DIGITS - 1);
   localparam logic [ND_W-1:0]  ND_MAX   = ND_W'(DIGITS);
   localparam logic [CNT_W-1:0] CONV_END = CNT_W'(VAL_W);
   localparam logic [CNT_W-1:0] MUL_END  = CNT_W'(VAL_W-1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_CONV, S_ERR} state_t;
   typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

   state_t               state, state_nx;
   op_t                  pend_op, new_op;
   logic [VAL_W-1:0]     acc, entry, conv_bin, conv_val, mplier;
   logic [ND_W-1:0]      ndig;
   logic                 result, err_pend, clr_pend;
   logic [W2-1:0]        mcand, prod, prod_nx, sum;
   logic [CNT_W-1:0]     cnt;
   logic [BCD_W-1:0]     bcd;
   logic [7*DIGITS-1:0]  disp_r, rst_disp, err_disp;
   logic [VAL_W-1:0]     digits_r, diff, eval_val, digit_val;
   logic                 is_digit, is_op, is_eq, is_clr, eval_bad;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0: seg7 = 7'h40;
         4'd1: seg7 = 7'h79;
         4'd2: seg7 = 7'h24;
         4'd3: seg7 = 7'h30;
         4'd4: seg7 = 7'h19;
         4'd5: seg7 = 7'h12;
         4'd6: seg7 = 7'h02;
         4'd7: seg7 = 7'h78;
         4'd8: seg7 = 7'h00;
         4'd9: seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
      logic [BCD_W-1:0] a;
      a = b;
      for (int i = 0; i < DIGITS; i++)
         if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      return {a[BCD_W-2:0], bit_in};
   endfunction

   // Leading zeros blank, but display 0 always shows a digit.
   function automatic logic [7*DIGITS-1:0] render(input logic [BCD_W-1:0] b);
      logic [7*DIGITS-1:0] s;
      logic lead;
      s = '1;
      lead = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
         if (lead && i != 0 && b[4*i +: 4] == 4'd0) s[7*i +: 7] = 7'h7F;
         else begin
            lead = 1'b0;
            s[7*i +: 7] = seg7(b[4*i +: 4]);
         end
      end
      return s;
   endfunction

   always_comb begin
      is_digit = (cmd <= 4'd9);
      is_op    = (cmd == 4'hA) || (cmd == 4'hB) || (cmd == 4'hC);
      is_eq    = (cmd == 4'hE);
      is_clr   = (cmd == 4'hD);
      case (cmd)
         4'hA:    new_op = OP_ADD;
         4'hB:    new_op = OP_SUB;
         4'hC:    new_op = OP_MUL;
         default: new_op = OP_NONE;
      endcase
      sum  = W2'(acc) + W2'(entry);
      diff = acc - entry;
      eval_bad = ((pend_op == OP_ADD) && (sum > MAX_W)) ||
                 ((pend_op == OP_SUB) && (entry > acc));
      // With no pending op, a fresh result stays as the left operand so it can be chained.
      case (pend_op)
         OP_ADD:  eval_val = sum[VAL_W-1:0];
         OP_SUB:  eval_val = diff;
         OP_NONE: eval_val = result ? acc : entry;
         default: eval_val = acc;
      endcase
      if (result)          digit_val = VAL_W'(cmd);
      else if (ndig < ND_MAX) digit_val = entry * VAL_W'(10) + VAL_W'(cmd);
      else                 digit_val = entry;
      prod_nx = prod + (mplier[0] ? mcand : '0);
      rst_disp = '1;
      rst_disp[6:0] = 7'h40;
      err_disp = '1;
      for (int i = 0; i < DIGITS; i++)
         err_disp[7*i +: 7] = (i == 2) ? 7'h06 : ((i < 2) ? 7'h2F : 7'h7F);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (!is_clr && (is_op || is_eq) && pend_op == OP_MUL) state_nx = S_MUL;
               else                                                   state_nx = S_CONV;
            end
         end
         S_MUL:  if (cnt == MUL_END) state_nx = S_CONV;
         S_CONV: begin
            if (err_pend)              state_nx = S_ERR;
            else if (clr_pend)         state_nx = S_IDLE;
            else if (cnt == CONV_END)  state_nx = S_IDLE;
         end
         S_ERR:  if (cmd_valid && is_clr) state_nx = S_CONV;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc <= '0; entry <= '0; ndig <= '0; pend_op <= OP_NONE; result <= 1'b0;
         err_pend <= 1'b0; clr_pend <= 1'b0; cnt <= '0; bcd <= '0;
         conv_bin <= '0; conv_val <= '0; mcand <= '0; mplier <= '0; prod <= '0;
         disp_r <= rst_disp; digits_r <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid) begin
               cnt <= '0;
               bcd <= '0;
               err_pend <= 1'b0;
               clr_pend <= 1'b0;
               if (is_clr) begin
                  clr_pend <= 1'b1;
               end else if (is_digit) begin
                  if (result)             ndig <= ND_W'(1);
                  else if (ndig < ND_MAX) ndig <= ndig + ND_W'(1);
                  entry    <= digit_val;
                  result   <= 1'b0;
                  conv_bin <= digit_val;
                  conv_val <= digit_val;
               end else if (is_op || is_eq) begin
                  if (pend_op == OP_MUL) begin
                     mcand  <= W2'(acc);
                     mplier <= entry;
                     prod   <= '0;
                  end else begin
                     acc      <= eval_val;
                     err_pend <= eval_bad;
                     conv_bin <= eval_val;
                     conv_val <= eval_val;
                  end
                  pend_op <= is_eq ? OP_NONE : new_op;
                  result  <= is_eq;
                  entry   <= '0;
                  ndig    <= '0;
               end else if (result) begin
                  conv_bin <= acc;
                  conv_val <= acc;
               end else begin
                  entry    <= entry / VAL_W'(10);
                  conv_bin <= entry / VAL_W'(10);
                  conv_val <= entry / VAL_W'(10);
                  if (ndig != '0) ndig <= ndig - ND_W'(1);
               end
            end
            S_MUL: begin
               prod   <= prod_nx;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == MUL_END) begin
                  acc      <= prod_nx[VAL_W-1:0];
                  conv_bin <= prod_nx[VAL_W-1:0];
                  conv_val <= prod_nx[VAL_W-1:0];
                  err_pend <= (prod_nx > MAX_W);
                  cnt      <= '0;
                  bcd      <= '0;
               end
            end
            S_CONV: begin
               if (err_pend) begin
                  err_pend <= 1'b0;
                  disp_r   <= err_disp;
                  digits_r <= '0;
               end else if (clr_pend) begin
                  clr_pend <= 1'b0;
                  acc <= '0; entry <= '0; ndig <= '0; pend_op <= OP_NONE; result <= 1'b0;
                  disp_r   <= rst_disp;
                  digits_r <= '0;
               end else if (cnt == CONV_END) begin
                  disp_r   <= render(bcd);
                  digits_r <= conv_val;
               end else begin
                  bcd      <= dabble(bcd, conv_bin[VAL_W-1]);
                  conv_bin <= conv_bin << 1;
                  cnt      <= cnt + CNT_W'(1);
               end
            end
            S_ERR: if (cmd_valid && is_clr) begin
               clr_pend <= 1'b1;
               cnt      <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (state)
         S_IDLE:  status = result ? 2'b11 : 2'b00;
         S_ERR:   status = 2'b10;
         default: status = 2'b01;
      endcase
   end

   assign cmd_ready = (state == S_IDLE) || (state == S_ERR);
   assign displays  = disp_r;
   assign digits    = digits_r;

endmodule

// File: tb/tb_calc_param.sv
// Bench for calc_param at DIGITS=4: driver pushes model expectations, an independent monitor checks each completed command.
module tb_calc_param;
   localparam int DIGITS = 4;
   localparam int VAL_W  = 14;
   localparam longint MAX = 9999;
   localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic                 clock = 1'b0;
   logic                 reset;
   logic [3:0]           cmd;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [7*DIGITS-1:0]  displays;
   logic [1:0]           status;
   logic [VAL_W-1:0]     digits;

   calc_param #(.DIGITS(DIGITS), .VAL_W(VAL_W)) dut (
      .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .displays(displays), .status(status), .digits(digits)
   );

   always #5 clock = ~clock;

   typedef struct {
      int                  lat;
      longint              dig;
      logic [1:0]          st;
      logic [7*DIGITS-1:0] disp;
   } exp_t;

   exp_t sbq[$];
   int n_checks = 0;
   int n_fail   = 0;

   longint m_acc, m_entry;
   int     m_ndig, m_pend;
   bit     m_res, m_err;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7*DIGITS-1:0] show_val(input longint v);
      logic [7*DIGITS-1:0] r;
      longint x;
      int i;
      r = '1;
      x = v;
      i = 0;
      do begin
         r[7*i +: 7] = SEG[x % 10];
         x = x / 10;
         i++;
      end while (x > 0 && i < DIGITS);
      return r;
   endfunction

   function automatic logic [7*DIGITS-1:0] err_disp();
      logic [7*DIGITS-1:0] r;
      r = '1;
      r[6:0]   = 7'h2F;
      r[13:7]  = 7'h2F;
      r[20:14] = 7'h06;
      return r;
   endfunction

   function automatic logic [7*DIGITS-1:0] rst_disp();
      logic [7*DIGITS-1:0] r;
      r = '1;
      r[6:0] = 7'h40;
      return r;
   endfunction

   task automatic model_reset();
      m_acc = 0; m_entry = 0; m_ndig = 0; m_pend = 0; m_res = 0; m_err = 0;
   endtask

   // Calculator semantics at the arithmetic level; pend: 0 none, 1 add, 2 sub, 3 mul.
   task automatic model(input logic [3:0] c, output exp_t e);
      longint r, shown;
      bit mul, bad;
      mul = 0; bad = 0; r = 0;
      if (c == 4'hD) begin
         model_reset();
         e.lat = 1; e.dig = 0; e.st = 2'b00; e.disp = rst_disp();
         return;
      end
      if (m_err) begin
         e.lat = 0; e.dig = 0; e.st = 2'b10; e.disp = err_disp();
         return;
      end
      if (c <= 4'd9) begin
         if (m_res) begin m_entry = 0; m_ndig = 0; m_res = 0; end
         if (m_ndig < DIGITS) begin m_entry = m_entry * 10 + longint'(c); m_ndig++; end
         shown = m_entry;
      end else if (c == 4'hF) begin
         if (!m_res) begin
            m_entry = m_entry / 10;
            if (m_ndig > 0) m_ndig--;
         end
         shown = m_res ? m_acc : m_entry;
      end else begin
         if (m_pend == 0) r = m_res ? m_acc : m_entry;
         else begin
            mul = (m_pend == 3);
            case (m_pend)
               1: r = m_acc + m_entry;
               2: r = m_acc - m_entry;
               default: r = m_acc * m_entry;
            endcase
            bad = (r < 0) || (r > MAX);
         end
         m_acc   = r;
         m_pend  = (c == 4'hE) ? 0 : int'(c) - 9;
         m_res   = (c == 4'hE);
         m_entry = 0;
         m_ndig  = 0;
         shown   = r;
      end
      if (bad) begin
         m_err = 1;
         e.lat = mul ? VAL_W + 1 : 1; e.dig = 0; e.st = 2'b10; e.disp = err_disp();
      end else begin
         e.lat = mul ? 2*VAL_W + 1 : VAL_W + 1;
         e.dig = shown; e.st = m_res ? 2'b11 : 2'b00; e.disp = show_val(shown);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic send(input logic [3:0] c, input bit pulse);
      exp_t e;
      model(c, e);
      sbq.push_back(e);
      cmd = c;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      if (pulse) begin
         repeat (3) @(posedge clock);
         #1;
         cmd = 4'($urandom_range(0, 9));
         cmd_valid = 1'b1;
         @(posedge clock); #1;
         cmd_valid = 1'b0;
      end
      wait_ready();
      @(posedge clock); #1;
   endtask

   task automatic send_abort(input logic [3:0] c);
      exp_t e;
      e.lat = -1; e.dig = 0; e.st = 2'b00; e.disp = rst_disp();
      sbq.push_back(e);
      model_reset();
      cmd = c;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("mid_mul_busy", 64'(status), 64'(2'b01));
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort_ready", 64'(cmd_ready), 64'(1));
      check("abort_status", 64'(status), 64'(2'b00));
      check("abort_digits", 64'(digits), 64'(0));
      check("abort_displays", 64'(displays), 64'(rst_disp()));
      @(posedge clock); #1;
   endtask

   initial begin : monitor
      exp_t e;
      int n;
      forever begin
         @(negedge clock);
         if (cmd_valid && cmd_ready && !reset) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_accept: cmd %0h accepted, expected none", cmd);
            end else begin
               e = sbq.pop_front();
               n = 0;
               @(negedge clock);
               while (!cmd_ready && n < 300) begin
                  n++;
                  @(negedge clock);
               end
               if (e.lat >= 0) check("busy_cycles", 64'(n), 64'(e.lat));
               check("digits", 64'(digits), 64'(e.dig));
               check("status", 64'(status), 64'(e.st));
               check("displays", 64'(displays), 64'(e.disp));
            end
         end
      end
   end

   initial begin : driver
      int wait_n;
      reset = 1'b1;
      cmd = 4'h0;
      cmd_valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check("rst_ready", 64'(cmd_ready), 64'(1));
      check("rst_status", 64'(status), 64'(2'b00));
      check("rst_digits", 64'(digits), 64'(0));
      check("rst_displays", 64'(displays), 64'(rst_disp()));

      // 123 + 45 = 168
      send(4'd1, 0); send(4'd2, 0); send(4'd3, 0); send(4'hA, 0);
      send(4'd4, 0); send(4'd5, 0); send(4'hE, 0);
      // 99 * 101 = 9999, then *2 overflows; digit ignored in ERR; clear
      send(4'd9, 0); send(4'd9, 0); send(4'hC, 0); send(4'd1, 0);
      send(4'd0, 0); send(4'd1, 0); send(4'hE, 0);
      send(4'hC, 0); send(4'd2, 0); send(4'hE, 0);
      send(4'd3, 0); send(4'hD, 0);
      // 5 - 7 underflows
      send(4'd5, 0); send(4'hB, 0); send(4'd7, 0); send(4'hE, 0); send(4'hD, 0);
      // digit limit and backspace down to 0
      send(4'd1, 0); send(4'd2, 0); send(4'd3, 0); send(4'd4, 0); send(4'd5, 0);
      for (int i = 0; i < 5; i++) send(4'hF, 0);
      // chain (2+3)*4 with dropped commands during BUSY
      send(4'd2, 1); send(4'hA, 1); send(4'd3, 1); send(4'hC, 0); send(4'd4, 1); send(4'hE, 0);
      // reset in the middle of a multiply
      send(4'd7, 0); send(4'hC, 0); send(4'd8, 0);
      send_abort(4'hE);

      for (int k = 0; k < 90; k++) begin
         int r;
         logic [3:0] c;
         r = $urandom_range(0, 99);
         if (m_err && r < 40) c = 4'hD;
         else if (r < 55)     c = 4'($urandom_range(0, 9));
         else if (r < 65)     c = 4'hA;
         else if (r < 73)     c = 4'hB;
         else if (r < 80)     c = 4'hC;
         else if (r < 88)     c = 4'hE;
         else if (r < 95)     c = 4'hF;
         else                 c = 4'hD;
         send(c, 0);
      end

      wait_n = 0;
      while (sbq.size() != 0 && wait_n < 500) begin
         @(posedge clock); #1;
         wait_n++;
      end
      if (sbq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
      end
      repeat (3) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
